branch_resolve_unit: RTL and testbench

- Parametrised, pipelined branch resolution unit for the RV32/RV64 execute stage.
- Accepts a branch op (funct3, rs1/rs2 values, PC, B-immediate, predicted direction) through a valid/ready handshake.
- Returns the resolved direction, the redirect PC and the mispredict flag two cycles later.
- Supports back-pressure and flush.
- Replaces the single-cycle combinational compare-only comparator.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond_eval.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: funct3 encodings and the S1 control payload.
// Optional statistics counters in the top are enabled with the BRU_STATS_EN macro.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [2:0] funct3;
    logic       pred_taken;
  } s1_payload_t;

  // 010 and 011 are the only reserved encodings in the branch major opcode.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: equality plus signed/unsigned less-than,
// selected by funct3.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt;
  logic                   ltu;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign eq    = rs1 == rs2;
  assign lt    = rs1_s < rs2_s;
  assign ltu   = rs1 < rs2;

  always_comb begin
    taken   = 1'b0;
    illegal = f3_is_illegal(funct3);
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution unit (S1 operands, S2 result) with valid/ready flow control and flush.
// Defining BRU_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  s1_payload_t     ctrl_p1_q, ctrl_p1_d;
  logic [XLEN-1:0] rs1_p1_q, rs1_p1_d;
  logic [XLEN-1:0] rs2_p1_q, rs2_p1_d;
  logic [XLEN-1:0] pc_p1_q, pc_p1_d;
  logic [XLEN-1:0] imm_p1_q, imm_p1_d;
  logic            vld_p1_q, vld_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic            taken_p2_q, taken_p2_d;
  logic [XLEN-1:0] redirect_p2_q, redirect_p2_d;
  logic            mispredict_p2_q, mispredict_p2_d;
  logic            illegal_p2_q, illegal_p2_d;

  logic            s2_adv;
  logic            accept;
  logic            load_p2;
  logic            taken_p1;
  logic            illegal_p1;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3  (ctrl_p1_q.funct3),
    .rs1     (rs1_p1_q),
    .rs2     (rs2_p1_q),
    .taken   (taken_p1),
    .illegal (illegal_p1)
  );

  always_comb begin
    s2_adv   = !vld_p2_q || out_ready;
    in_ready = (!vld_p1_q || s2_adv) && !flush;
    accept   = in_valid && in_ready;
    load_p2  = s2_adv && vld_p1_q && !flush;

    ctrl_p1_d = ctrl_p1_q;
    rs1_p1_d  = rs1_p1_q;
    rs2_p1_d  = rs2_p1_q;
    pc_p1_d   = pc_p1_q;
    imm_p1_d  = imm_p1_q;
    if (accept) begin
      ctrl_p1_d.funct3     = in_funct3;
      ctrl_p1_d.pred_taken = in_pred_taken;
      rs1_p1_d             = in_rs1;
      rs2_p1_d             = in_rs2;
      pc_p1_d              = in_pc;
      imm_p1_d             = in_imm;
    end

    // Flush beats both accept and stall; an empty or draining S1 refills from the input.
    if (flush)       vld_p1_d = 1'b0;
    else if (accept) vld_p1_d = 1'b1;
    else if (s2_adv) vld_p1_d = 1'b0;
    else             vld_p1_d = vld_p1_q;

    if (flush)       vld_p2_d = 1'b0;
    else if (s2_adv) vld_p2_d = vld_p1_q;
    else             vld_p2_d = vld_p2_q;

    taken_p2_d      = taken_p2_q;
    redirect_p2_d   = redirect_p2_q;
    mispredict_p2_d = mispredict_p2_q;
    illegal_p2_d    = illegal_p2_q;
    if (load_p2) begin
      taken_p2_d      = taken_p1;
      redirect_p2_d   = taken_p1 ? (pc_p1_q + imm_p1_q) : (pc_p1_q + XLEN'(ILEN_BYTES));
      mispredict_p2_d = taken_p1 != ctrl_p1_q.pred_taken;
      illegal_p2_d    = illegal_p1;
    end
  end

  // ---- S1: operand register (data needs no reset, vld_p1_q qualifies it) ----
  always_ff @(posedge clk) begin
    ctrl_p1_q <= ctrl_p1_d;
    rs1_p1_q  <= rs1_p1_d;
    rs2_p1_q  <= rs2_p1_d;
    pc_p1_q   <= pc_p1_d;
    imm_p1_q  <= imm_p1_d;
  end

  // ---- S2: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q        <= 1'b0;
      vld_p2_q        <= 1'b0;
      taken_p2_q      <= 1'b0;
      redirect_p2_q   <= '0;
      mispredict_p2_q <= 1'b0;
      illegal_p2_q    <= 1'b0;
    end else begin
      vld_p1_q        <= vld_p1_d;
      vld_p2_q        <= vld_p2_d;
      taken_p2_q      <= taken_p2_d;
      redirect_p2_q   <= redirect_p2_d;
      mispredict_p2_q <= mispredict_p2_d;
      illegal_p2_q    <= illegal_p2_d;
    end
  end

  assign out_valid       = vld_p2_q;
  assign out_taken       = taken_p2_q;
  assign out_redirect_pc = redirect_p2_q;
  assign out_mispredict  = mispredict_p2_q;
  assign out_illegal     = illegal_p2_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;
  logic        done;

  always_comb begin
    // An op sitting in S2 on a flush edge is killed, so it is not counted.
    done      = vld_p2_q && out_ready && !flush;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (done && stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
    if (done && mispredict_p2_q && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected results;
// counter checks are compiled in when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = 3'b000;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic            in_pred_taken = 1'b0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_taken;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .ILEN_BYTES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_funct3       (in_funct3),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_pred_taken   (in_pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_taken       (out_taken),
    .out_redirect_pc (out_redirect_pc),
    .out_mispredict  (out_mispredict),
    .out_illegal     (out_illegal)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] redirect;
    logic            mispredict;
    logic            illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  logic rdy_s  = 1'b0;
  logic acc_s  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] imm, input logic pred);
    exp_t e;
    e.illegal = 1'b0;
    case (f3)
      3'b000:  e.taken = (a == b);
      3'b001:  e.taken = (a != b);
      3'b100:  e.taken = ($signed(a) < $signed(b));
      3'b101:  e.taken = ($signed(a) >= $signed(b));
      3'b110:  e.taken = (a < b);
      3'b111:  e.taken = (a >= b);
      default: begin e.taken = 1'b0; e.illegal = 1'b1; end
    endcase
    e.redirect   = e.taken ? pc + imm : pc + 32'd4;
    e.mispredict = e.taken ^ pred;
    return e;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pred);
    in_valid      = 1'b1;
    in_funct3     = f3;
    in_rs1        = a;
    in_rs2        = b;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
  endtask

  // Called at posedge+1; samples handshakes at posedge+2 and returns at the next posedge+1.
  task automatic tick();
    exp_t e;
    #1;
    rdy_s = in_ready;
    acc_s = in_valid && in_ready;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected observed=out_valid expected=no_result_pending");
      end else begin
        e = sb.pop_front();
        popped++;
        chk("sb_taken", 64'(out_taken), 64'(e.taken));
        chk("sb_redirect", 64'(out_redirect_pc), 64'(e.redirect));
        chk("sb_mispredict", 64'(out_mispredict), 64'(e.mispredict));
        chk("sb_illegal", 64'(out_illegal), 64'(e.illegal));
      end
    end
    if (flush) sb.delete();
    if (acc_s) sb.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  exp_t snap;
  int   base;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_taken", 64'(out_taken), 0);
    chk("rst_redirect", 64'(out_redirect_pc), 0);
    chk("rst_mispredict", 64'(out_mispredict), 0);
    chk("rst_illegal", 64'(out_illegal), 0);

    // BLT signed then BLTU with identical operands
    drive(F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    tick();
    chk("blt_accept", 64'(acc_s), 1);
    in_valid = 1'b0;
    chk("blt_lat1_valid", 64'(out_valid), 0);
    tick();
    chk("blt_lat2_valid", 64'(out_valid), 1);
    chk("blt_taken", 64'(out_taken), 1);
    chk("blt_redirect", 64'(out_redirect_pc), 32'h120);
    chk("blt_mispredict", 64'(out_mispredict), 1);
    drive(F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("bltu_valid", 64'(out_valid), 1);
    chk("bltu_taken", 64'(out_taken), 0);
    chk("bltu_redirect", 64'(out_redirect_pc), 32'h104);
    chk("bltu_mispredict", 64'(out_mispredict), 0);
    drain(5);

    // Full throughput with out_ready held high
    for (int i = 0; i < 4; i++) begin
      drive(F3_BNE, 32'(i), 32'h2, 32'h200 + 32'(16 * i), 32'hFFFF_FFF8, 1'(i));
      tick();
      chk("tput_ready", 64'(rdy_s), 1);
    end
    drain(10);

    // Back-pressure: out_ready low for three cycles while streaming four ops
    base = popped;
    out_ready = 1'b0;
    drive(F3_BGE, 32'h3, 32'h7, 32'h400, 32'h10, 1'b1);
    tick();
    chk("bp_acc0", 64'(acc_s), 1);
    drive(F3_BGEU, 32'h8000_0000, 32'h7, 32'h410, 32'h30, 1'b1);
    tick();
    chk("bp_acc1", 64'(acc_s), 1);
    drive(F3_BEQ, 32'h9, 32'h9, 32'h420, 32'h44, 1'b0);
    chk("bp_s2_valid", 64'(out_valid), 1);
    snap = {out_taken, out_redirect_pc, out_mispredict, out_illegal};
    tick();
    chk("bp_ready_drop", 64'(rdy_s), 0);
    chk("bp_stable", 64'({out_taken, out_redirect_pc, out_mispredict, out_illegal}), 64'(snap));
    out_ready = 1'b1;
    tick();
    chk("bp_acc2", 64'(acc_s), 1);
    drive(F3_BLTU, 32'h5, 32'h6, 32'h430, 32'h8, 1'b0);
    tick();
    chk("bp_acc3", 64'(acc_s), 1);
    drain(12);
    chk("bp_count", 64'(popped - base), 4);

    // Flush with S1 and S2 full and a new op presented
    out_ready = 1'b0;
    drive(F3_BEQ, 32'h1, 32'h1, 32'h500, 32'h8, 1'b1);
    tick();
    drive(F3_BNE, 32'h1, 32'h1, 32'h510, 32'h8, 1'b1);
    tick();
    drive(F3_BLT, 32'h0, 32'h1, 32'h520, 32'h8, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("flush_no_accept", 64'(acc_s), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 0);
    tick();
    chk("flush_s1_cleared", 64'(out_valid), 0);
    drive(F3_BGE, 32'h7, 32'h7, 32'h600, 32'h100, 1'b0);
    tick();
    chk("post_flush_accept", 64'(acc_s), 1);
    in_valid = 1'b0;
    chk("post_flush_lat1", 64'(out_valid), 0);
    tick();
    chk("post_flush_lat2", 64'(out_valid), 1);
    chk("post_flush_redirect", 64'(out_redirect_pc), 32'h700);
    drain(5);

    // PC wrap-around and an illegal funct3, back to back
    drive(F3_BEQ, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1);
    tick();
    drive(3'b010, 32'h1, 32'h2, 32'h300, 32'h40, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("wrap_taken", 64'(out_taken), 1);
    chk("wrap_redirect", 64'(out_redirect_pc), 32'h10);
    chk("wrap_mispredict", 64'(out_mispredict), 0);
    tick();
    chk("ill_illegal", 64'(out_illegal), 1);
    chk("ill_taken", 64'(out_taken), 0);
    chk("ill_mispredict", 64'(out_mispredict), 1);
    drain(5);

    // Asynchronous reset pulse in the middle of a stall
    out_ready = 1'b0;
    drive(F3_BEQ, 32'h1, 32'h1, 32'h800, 32'h4, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall_valid", 64'(out_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_taken", 64'(out_taken), 0);
    #2 rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("arst_after_valid", 64'(out_valid), 0);
    chk("arst_after_ready", 64'(in_ready), 1);
`ifdef BRU_STATS_EN
    chk("stat_br_zero", 64'(stat_branches), 0);
    chk("stat_mp_zero", 64'(stat_mispredicts), 0);
`endif
    out_ready = 1'b1;
    drive(F3_BEQ, 32'h1, 32'h1, 32'h800, 32'h4, 1'b0);
    tick();
    chk("arst_reaccept", 64'(acc_s), 1);
    drain(6);
`ifdef BRU_STATS_EN
    chk("stat_br_one", 64'(stat_branches), 1);
    chk("stat_mp_one", 64'(stat_mispredicts), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
